multicycle_controller: RTL

Sequencing controller for the multicycle variant of the RV32I core. One shared memory port and one ALU serve every instruction, so each instruction runs as a sequence of 3–5 states. A Moore FSM plus combinational ALU and immediate decoders drive every datapath select and write enable. It sits beside the multicycle datapath, takes the opcode and function fields from the instruction register plus the ALU `zero` flag, and produces the per-cycle controls.

---
 rtl/multicycle_controller.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// RV32I multicycle sequencer: Moore FSM (3-5 states/instr), combinational controls, no backpressure.
// Optional RV_MC_BNE_EN adds bne; without it every branch behaves as beq.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic       regwrite,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       retire,
  output logic       illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] aluop;
  logic       pcupdate, branch, take;
  logic       irwrite_raw, memwrite_raw, regwrite_raw, retire_raw, illegal_raw;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = S_FETCH;
    aluop        = 2'b00;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    adrsrc       = 1'b0;
    resultsrc    = 2'b00;
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    retire_raw   = 1'b0;
    illegal_raw  = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        pcupdate    = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
`ifdef RV_MC_BNE_EN
          OP_BR: begin
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
              state_d = S_BEQ;
            end else begin
              illegal_raw = 1'b1;
            end
          end
`else
          OP_BR:        state_d = S_BEQ;
`endif
          default:      illegal_raw = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc    = 2'b01;
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
        retire_raw   = 1'b1;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
      end
      S_BEQ: begin
        alusrca    = 2'b10;
        aluop      = 2'b01;
        branch     = 1'b1;
        retire_raw = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

`ifdef RV_MC_BNE_EN
  assign take = (funct3 == 3'b001) ? ~zero : zero;
`else
  assign take = zero;
`endif

  // Enables are suppressed during reset; mux selects are left untouched.
  assign pcwrite  = ~reset & (pcupdate | (branch & take));
  assign irwrite  = ~reset & irwrite_raw;
  assign memwrite = ~reset & memwrite_raw;
  assign regwrite = ~reset & regwrite_raw;
  assign retire   = ~reset & retire_raw;
  assign illegal  = ~reset & illegal_raw;

  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BR:   immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

endmodule
